// File: rtl/adder_err_eval_pkg.sv
// Shared defaults, controller state encoding and the error-magnitude helper.
package adder_err_eval_pkg;

  localparam int          WIDTH_DEF     = 16;
  localparam logic [31:0] LFSR_POLY_DEF = 32'h80200003;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // |exact - approx| on zero-extended operands; callers truncate to sum width + 0,
  // since the magnitude of a difference of two (W+1)-bit values fits in W+1 bits.
  function automatic logic [63:0] abs_diff(input logic [63:0] exact,
                                           input logic [63:0] approx);
    return (exact >= approx) ? (exact - approx) : (approx - exact);
  endfunction

endpackage

// File: rtl/err_eval_lfsr.sv
// Right-shifting Galois LFSR used as the operand-pair generator.
module err_eval_lfsr
  import adder_err_eval_pkg::*;
#(
  parameter int         W    = 32,
  parameter logic [W-1:0] POLY = W'(LFSR_POLY_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] nxt;
  logic [W-1:0] seed_fix;

  // An all-zero state would lock up, so a zero seed becomes 1.
  assign seed_fix = (seed == '0) ? W'(1) : seed;
  assign nxt      = {1'b0, q[W-1:1]} ^ (q[0] ? POLY : '0);

  // Load has priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= W'(1);
    else if (load) q <= seed_fix;
    else if (en)   q <= nxt;
  end

endmodule

// File: rtl/adder_err_eval_ctrl.sv
// Error-evaluation sequencer for an external approximate adder: drives LFSR
// operand pairs, compares the returned sum against the exact sum two stages
// later and accumulates error count, max and total absolute error.
module adder_err_eval_ctrl
  import adder_err_eval_pkg::*;
#(
  parameter int                 WIDTH     = WIDTH_DEF,
  parameter int                 CNT_W     = 32,
  parameter logic [2*WIDTH-1:0] LFSR_POLY = (2*WIDTH)'(LFSR_POLY_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       cfg_num_vectors,
  input  logic [2*WIDTH-1:0]     cfg_seed,
  output logic [WIDTH-1:0]       dut_a,
  output logic [WIDTH-1:0]       dut_b,
  input  logic [WIDTH:0]         dut_sum,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       err_count,
  output logic [WIDTH:0]         max_abs_err,
  output logic [WIDTH+CNT_W:0]   sum_abs_err
);

  localparam int SW = WIDTH + 1;
  localparam int LW = 2 * WIDTH;
  localparam int AW = WIDTH + 1 + CNT_W;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [LW-1:0]    lfsr_q;
  logic             vec_ok;
  logic             accept, issue, last, lfsr_load, lfsr_en;
  logic             s1_vld;
  logic [SW-1:0]    s1_exact, s1_approx, diff;

  assign accept    = (state == IDLE) && start;
  assign issue     = (state == RUN);
  assign last      = (remaining == CNT_W'(1));
  // An empty run leaves the LFSR (and so the driven operands) untouched.
  assign lfsr_load = accept && (cfg_num_vectors != '0);
  // The final vector is not stepped past, so the operands hold it afterwards.
  assign lfsr_en   = issue && !last;

  err_eval_lfsr #(.W(LW), .POLY(LFSR_POLY)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .seed (cfg_seed),
    .en   (lfsr_en),
    .q    (lfsr_q)
  );

  // Operands read as zero until a run has loaded the generator.
  assign dut_a = vec_ok ? lfsr_q[LW-1:WIDTH] : '0;
  assign dut_b = vec_ok ? lfsr_q[WIDTH-1:0]  : '0;
  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);
  assign diff  = SW'(abs_diff(64'(s1_exact), 64'(s1_approx)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: an empty run passes through DRAIN, which finds the pipe empty
  // at once, so busy is seen for one cycle before the done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_num_vectors == '0) ? DRAIN : RUN;
      RUN:     if (last) state_nxt = DRAIN;
      DRAIN:   if (!s1_vld) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remaining-vector counter and operand-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      vec_ok    <= 1'b0;
    end else begin
      if (accept)     remaining <= cfg_num_vectors;
      else if (issue) remaining <= remaining - CNT_W'(1);
      if (lfsr_load)  vec_ok <= 1'b1;
    end
  end

  // Stage 1: capture exact and approximate sums of the vector driven this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_exact  <= '0;
      s1_approx <= '0;
    end else begin
      s1_vld <= issue;
      if (issue) begin
        s1_exact  <= {1'b0, dut_a} + {1'b0, dut_b};
        s1_approx <= dut_sum;
      end
    end
  end

  // Stage 2: fold the stage-1 error into the metrics; cleared on accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
    end else if (accept) begin
      err_count   <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
    end else if (s1_vld) begin
      err_count   <= err_count + CNT_W'(diff != '0);
      if (diff > max_abs_err) max_abs_err <= diff;
      sum_abs_err <= sum_abs_err + AW'(diff);
    end
  end

endmodule
